serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial ripple adder that feeds operands LSB-first, one bit per clock, through a single `full_addd` cell. A registered carry provides the carry-in for each next bit. It adds a WIDTH-bit result path to the arithmetic set while using one full-adder cell instead of a WIDTH-bit ripple chain. It is controlled by a start/busy/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  initial carry-in; captured on accepted start
- busy  output  1  high while bits are being processed (SHIFT)
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result; held until next completion
- cout  output  1  registered final carry-out; held with sum

## Operation
- Clocking and reset: one clock, clk; rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy=0, done=0, sum=0, cout=0; all internal registers (operand shift registers, partial-sum register, carry register, bit counter) are 0.
- States: IDLE, SHIFT, DONE.
  - IDLE: start=1 -> load a_sr<=a, b_sr<=b, carry_q<=cin, cnt<=0; go to SHIFT. start=0 -> stay in IDLE.
  - SHIFT: the cell sees a_sr[0], b_sr[0], carry_q. On every edge:
    - a_sr and b_sr shift right by 1.
    - The cell's sum bit enters the partial-sum register at the MSB; that register shifts right.
    - carry_q takes the cell's carry output.
    - cnt increments.
  - SHIFT exit: on the edge where cnt==WIDTH-1, the last bit is processed, and the same edge does all of:
    - sum <= completed partial sum, with the final bit in place;
    - cout <= the cell's carry output;
    - go to DONE.
  - DONE: lasts exactly one cycle, then goes to IDLE. start=1 here is accepted exactly as in IDLE, loads the new operands and goes straight to SHIFT.
- Output decode: busy = (state==SHIFT); done = (state==DONE). Both are registered-state decodes, with no combinational path from start.
- Start while busy: start=1 during SHIFT is ignored. Operands are not re-captured, the count is not disturbed, and no error is flagged.
- Operand stability: a, b and cin may change freely after the accepting edge.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1); no overflow flag.
- Counter width: cnt is $clog2(WIDTH) bits and never wraps past WIDTH-1.
- Reset mid-operation: rst_n low at any point returns the block to IDLE with all outputs 0. No done pulse is produced for the aborted operation.

## Timing
- Latency: start accepted at edge t0 -> busy=1 for cycles t0+1 through t0+WIDTH -> done=1 in cycle t0+WIDTH+1 only.
- Result visibility: sum and cout change only on the edge entering DONE. They are stable from that cycle until the next operation completes, including throughout the next operation's SHIFT phase.
- Throughput: back-to-back operations with start held high give one result per WIDTH+1 cycles.

## Structure
- Shared package serial_adder_pkg:
  - state typedef enum {IDLE, SHIFT, DONE} with 2-bit encoding.
  - localparam for the counter width, derived from WIDTH, via a function in the package.
- Sub-module: exactly one instance of the existing `full_addd`. Its ports connect as: a=a_sr[0], b=b_sr[0], c=carry_q; sum and carry feed the registers. No other arithmetic in the block.

## Test plan
- WIDTH=8, a=0x00, b=0x00, cin=0 -> done in cycle t0+9, sum=0x00, cout=0; busy high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
- Start for a=0x10, b=0x20, then pulse start with a=0xFF, b=0xFF at cycle t0+3 -> second start ignored; result sum=0x30, cout=0; a single done pulse.
- Start for a=0x0F, b=0x01; drive rst_n=0 at cycle t0+4 for one cycle -> busy, done, sum and cout all 0 immediately. State is IDLE with no done pulse. A subsequent start for a=0x03, b=0x04 gives sum=0x07.
- Start held high continuously, with operands changed each DONE cycle -> done every 9 cycles. Each result matches its own operands, and sum holds between pulses.
- WIDTH=2, exhaustively all a, b, cin (32 cases) -> {cout,sum} equals a+b+cin for every case, checked against a behavioural model.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit counter width: enough to index bits 0..w-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_full_addd.sv
// Single-bit full adder cell used by the serial datapath.
module full_addd (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  always_comb begin
    sum   = a ^ b ^ c;
    carry = (a & b) | (c & (a ^ b));
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB-first, start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum, fa_carry;
  logic             accept, last;

  full_addd u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_comb begin
    accept = start && ((state_q == IDLE) || (state_q == DONE));
    last   = (state_q == SHIFT) && (cnt_q == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  // The last bit is merged straight into sum_d so the result lands on the DONE edge.
  always_comb begin
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept) begin
      a_sr_d  = a;
      b_sr_d  = b;
      psum_d  = '0;
      carry_d = cin;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      a_sr_d  = a_sr_q >> 1;
      b_sr_d  = b_sr_q >> 1;
      psum_d  = {fa_sum, psum_q[WIDTH-1:1]};
      carry_d = fa_carry;
      if (last) begin
        sum_d  = {fa_sum, psum_q[WIDTH-1:1]};
        cout_d = fa_carry;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=2.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;

  int checks = 0;
  int passes = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int unsigned r;
    r = int'(x) + int'(y) + int'(c);
    return 9'(r % 512);
  endfunction

  task automatic start8_op(input logic [7:0] x, input logic [7:0] y, input logic c);
    @(negedge clk);
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (done8) return;
    end
    n = -1;
  endtask

  task automatic test_reset();
    checks++; if (busy8 !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy8); else passes++;
    checks++; if (done8 !== 1'b0) $display("FAIL reset_done: got %b exp 0", done8); else passes++;
    checks++; if (sum8 !== 8'h00) $display("FAIL reset_sum: got %0h exp 0", sum8); else passes++;
    checks++; if (cout8 !== 1'b0) $display("FAIL reset_cout: got %b exp 0", cout8); else passes++;
    checks++; if ({busy2, done2, cout2, sum2} !== 5'b0) $display("FAIL reset_w2: got %b exp 0", {busy2, done2, cout2, sum2}); else passes++;
  endtask

  task automatic test_latency_zero();
    logic [9:0] busy_pat, done_pat;
    logic [7:0] s_at;
    logic       c_at;
    busy_pat = '0; done_pat = '0; s_at = 8'hxx; c_at = 1'bx;
    start8_op(8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      busy_pat[i] = busy8;
      done_pat[i] = done8;
      if (done8) begin s_at = sum8; c_at = cout8; end
    end
    checks++; if (busy_pat !== 10'b00_1111_1111) $display("FAIL latency_busy: got %b exp 0011111111", busy_pat); else passes++;
    checks++; if (done_pat !== 10'b01_0000_0000) $display("FAIL latency_done: got %b exp 0100000000", done_pat); else passes++;
    checks++; if (s_at !== 8'h00) $display("FAIL zero_sum: got %0h exp 0", s_at); else passes++;
    checks++; if (c_at !== 1'b0) $display("FAIL zero_cout: got %b exp 0", c_at); else passes++;
  endtask

  task automatic test_directed();
    logic [7:0] ta [3] = '{8'hFF, 8'h7F, 8'hA5};
    logic [7:0] tb [3] = '{8'h01, 8'h01, 8'h5A};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] te [3] = '{9'h100, 9'h080, 9'h100};
    int n;
    for (int i = 0; i < 3; i++) begin
      start8_op(ta[i], tb[i], tc[i]);
      wait_done8(n);
      checks++; if (n != 9) $display("FAIL directed_latency[%0d]: got %0d exp 9", i, n); else passes++;
      checks++; if ({cout8, sum8} !== te[i]) $display("FAIL directed_result[%0d]: got %0h exp %0h", i, {cout8, sum8}, te[i]); else passes++;
    end
  endtask

  task automatic test_start_ignored();
    int         donec;
    logic [8:0] res;
    donec = 0; res = 'x;
    start8_op(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) begin donec++; res = {cout8, sum8}; end
    end
    checks++; if (donec != 1) $display("FAIL ignore_done_count: got %0d exp 1", donec); else passes++;
    checks++; if (res !== 9'h030) $display("FAIL ignore_result: got %0h exp 030", res); else passes++;
    checks++; if (busy8 !== 1'b0) $display("FAIL ignore_idle: got busy %b exp 0", busy8); else passes++;
  endtask

  task automatic test_reset_mid();
    int donec, busyc, n;
    donec = 0; busyc = 0;
    start8_op(8'h0F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy8 !== 1'b0) $display("FAIL midrst_busy: got %b exp 0", busy8); else passes++;
    checks++; if (done8 !== 1'b0) $display("FAIL midrst_done: got %b exp 0", done8); else passes++;
    checks++; if (sum8 !== 8'h00) $display("FAIL midrst_sum: got %0h exp 0", sum8); else passes++;
    checks++; if (cout8 !== 1'b0) $display("FAIL midrst_cout: got %b exp 0", cout8); else passes++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) donec++;
      if (busy8) busyc++;
    end
    checks++; if (donec != 0 || busyc != 0) $display("FAIL midrst_quiet: got done %0d busy %0d exp 0 0", donec, busyc); else passes++;
    start8_op(8'h03, 8'h04, 1'b0);
    wait_done8(n);
    checks++; if (n != 9 || {cout8, sum8} !== 9'h007) $display("FAIL midrst_after: got lat %0d res %0h exp 9 007", n, {cout8, sum8}); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q [$];
    logic [8:0] prev, e;
    int         n, holdbad;
    holdbad = 0; prev = 'x;
    @(negedge clk);
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'b1;
    exp_q.push_back(model8(a8, b8, cin8));
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (!done8 && k > 0 && {cout8, sum8} !== prev) holdbad++;
      end while (!done8 && n < 30);
      checks++; if (n != 9) $display("FAIL b2b_period[%0d]: got %0d exp 9", k, n); else passes++;
      e = exp_q.pop_front();
      checks++; if ({cout8, sum8} !== e) $display("FAIL b2b_result[%0d]: got %0h exp %0h", k, {cout8, sum8}, e); else passes++;
      prev = e;
      if (k < 4) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        exp_q.push_back(model8(a8, b8, cin8));
      end else begin
        start8 = 1'b0;
      end
    end
    checks++; if (holdbad != 0) $display("FAIL b2b_hold: got %0d changes exp 0", holdbad); else passes++;
    @(negedge clk);
  endtask

  task automatic test_random8();
    logic [7:0] x, y;
    logic       c;
    logic [8:0] e;
    int         n;
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      e = model8(x, y, c);
      start8_op(x, y, c);
      wait_done8(n);
      checks++; if (n != 9 || {cout8, sum8} !== e) $display("FAIL random[%0d]: got lat %0d res %0h exp 9 %0h", i, n, {cout8, sum8}, e); else passes++;
    end
  endtask

  task automatic test_w2_exhaustive();
    int latbad, n;
    int unsigned e;
    latbad = 0;
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          a2 = 2'(ia); b2 = 2'(ib); cin2 = 1'(ic); start2 = 1'b1;
          @(posedge clk);
          #1;
          start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
          n = 0;
          do begin
            @(negedge clk);
            n++;
          end while (!done2 && n < 10);
          if (n != 3) latbad++;
          e = ia + ib + ic;
          checks++; if ({cout2, sum2} !== 3'(e)) $display("FAIL w2[%0d+%0d+%0d]: got %0d exp %0d", ia, ib, ic, {cout2, sum2}, e); else passes++;
        end
    checks++; if (latbad != 0) $display("FAIL w2_latency: got %0d bad exp 0", latbad); else passes++;
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_latency_zero();
    test_directed();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random8();
    test_w2_exhaustive();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
